// File: rtl/axi_address_decoder_gen_pkg.sv
// Shared types and helpers for the AXI address decoder.
//   dec_state_e : decoder FSM states
//   ERR_CNT_W   : width of the optional decode-error counter
//   lowest_one  : isolates the lowest set bit of a vector (port priority)
package axi_dec_pkg;

  typedef enum logic [1:0] {
    OPERATIVE,
    DRAIN,
    ACCEPT_WDATA,
    ERROR_RESP
  } dec_state_e;

  localparam int ERR_CNT_W = 16;
  localparam int MAX_PORTS = 64;

  // v & -v keeps only the lowest set bit; callers zero-extend and truncate.
  function automatic logic [MAX_PORTS-1:0] lowest_one(input logic [MAX_PORTS-1:0] v);
    return v & (~v + MAX_PORTS'(1));
  endfunction

endpackage

// File: rtl/axi_address_decoder_gen_if.sv
// Request/route bundle between the slave-port request block, the decoder
// and the per-master-port arbiters / destination FIFO.
//   valid_i, addr_i, ready_o     : address handshake from the slave port
//   valid_o, ready_i             : one-hot handshake towards master ports
//   dest_o, push_dest_o          : decoded destination and FIFO push
//   grant_fifo_dest_i            : destination FIFO has space
// Modport slave is the decoder view, master is the driver (slave port) view.
interface axi_address_decoder_gen_if
  import axi_dec_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_INIT_PORT = 8
);

  logic                   valid_i;
  logic [ADDR_WIDTH-1:0]  addr_i;
  logic                   ready_o;
  logic [N_INIT_PORT-1:0] valid_o;
  logic [N_INIT_PORT-1:0] ready_i;
  logic [N_INIT_PORT-1:0] dest_o;
  logic                   push_dest_o;
  logic                   grant_fifo_dest_i;

  modport slave (
    input  valid_i, addr_i, ready_i, grant_fifo_dest_i,
    output ready_o, valid_o, dest_o, push_dest_o
  );

  modport master (
    output valid_i, addr_i, ready_i, grant_fifo_dest_i,
    input  ready_o, valid_o, dest_o, push_dest_o
  );

endinterface

// File: rtl/axi_address_decoder_gen_region_match.sv
// Combinational address-range compare for all ports and regions.
//   i_addr              : address under decode
//   i_start_addr/i_end_addr : inclusive bounds, slot index = region*N_INIT_PORT + port
//   i_enable_region     : per-slot enable, same indexing
//   i_connectivity_map  : ports reachable from this slave port
//   o_match             : per-port hit vector (may have several bits set)
module axi_dec_region_match
  import axi_dec_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_INIT_PORT = 8,
  parameter int N_REGION    = 2
) (
  input  logic [ADDR_WIDTH-1:0]                      i_addr,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] i_start_addr,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] i_end_addr,
  input  logic [N_REGION*N_INIT_PORT-1:0]            i_enable_region,
  input  logic [N_INIT_PORT-1:0]                     i_connectivity_map,
  output logic [N_INIT_PORT-1:0]                     o_match
);

  for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_port
    logic [N_REGION-1:0] w_port_hit;
    for (genvar r = 0; r < N_REGION; r++) begin : g_region
      localparam int IDX = r*N_INIT_PORT + p;
      assign w_port_hit[r] = i_enable_region[IDX]
                          && (i_addr >= i_start_addr[IDX*ADDR_WIDTH +: ADDR_WIDTH])
                          && (i_addr <= i_end_addr[IDX*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    assign o_match[p] = (|w_port_hit) && i_connectivity_map[p];
  end

endmodule

// File: rtl/axi_address_decoder_gen.sv
// Single-master AXI address decoder for the AR or AW channel.
// Routes each request to the lowest-index matching master port, holds off a
// change of destination until earlier transactions have retired, and sinks
// unmapped requests through an in-line error sequence.
// Optional feature macro: AXI_DEC_ERR_CNT_EN adds the err_count_o port and a
// saturating 16-bit decode-error counter.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   bus (slave modport)      : address handshake, one-hot valid/ready, dest FIFO push
//   resp_done_i              : last response beat retired
//   START_ADDR_i/END_ADDR_i  : region bounds, enable_region_i, connectivity_map_i
//   outstanding_o            : outstanding transaction count
//   error_req_o/error_gnt_i  : error response slot handshake
//   handle_error_o           : error write data sink active (WRITE_MODE=1)
//   wdata_error_completed_i  : error write data fully consumed
//   sample_info_o            : strobe to capture ID/len of the erroring request
//   err_count_o              : decode-error count (AXI_DEC_ERR_CNT_EN only)
//
// state        | meaning
// OPERATIVE    | decoding and issuing requests
// DRAIN        | error accepted, waiting for outstanding count to reach 0
// ACCEPT_WDATA | sinking write data of the erroring request
// ERROR_RESP   | requesting the error response slot
module axi_address_decoder_gen
  import axi_dec_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int N_INIT_PORT     = 8,
  parameter int N_REGION        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WRITE_MODE      = 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  axi_address_decoder_gen_if.slave                   bus,
  input  logic                                       resp_done_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
  input  logic [N_INIT_PORT-1:0]                     connectivity_map_i,
  output logic [CNT_W-1:0]                           outstanding_o,
  output logic                                       error_req_o,
  input  logic                                       error_gnt_i,
  output logic                                       handle_error_o,
  input  logic                                       wdata_error_completed_i,
`ifdef AXI_DEC_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]                       err_count_o,
`endif
  output logic                                       sample_info_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  dec_state_e             r_state;
  logic [CNT_W-1:0]       r_count;
  logic [N_INIT_PORT-1:0] r_last_dest;
  logic                   r_error_req;
  logic                   r_handle_error;

  logic [N_INIT_PORT-1:0] w_match;
  logic [N_INIT_PORT-1:0] w_dest;
  logic                   w_hit;
  logic                   w_stall;
  logic                   w_operative;
  logic                   w_issue;
  logic                   w_handshake;
  logic                   w_err_accept;
  logic                   w_dec;

  axi_dec_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_INIT_PORT (N_INIT_PORT),
    .N_REGION    (N_REGION)
  ) u_region_match (
    .i_addr             (bus.addr_i),
    .i_start_addr       (START_ADDR_i),
    .i_end_addr         (END_ADDR_i),
    .i_enable_region    (enable_region_i),
    .i_connectivity_map (connectivity_map_i),
    .o_match            (w_match)
  );

  assign w_dest      = N_INIT_PORT'(lowest_one(MAX_PORTS'(w_match)));
  assign w_hit       = |w_match;
  // Reset gates the combinational path so nothing is issued mid-reset.
  assign w_operative = (r_state == OPERATIVE) && !rst;

  // Switching destination while transactions are in flight would break
  // AXI response ordering, so hold until the count drains.
  assign w_stall = (r_count == CNT_MAX)
                || ((r_count != '0) && (w_dest != r_last_dest))
                || !bus.grant_fifo_dest_i;

  assign w_issue      = w_operative && bus.valid_i && w_hit && !w_stall;
  assign w_handshake  = w_issue && (|(bus.ready_i & w_dest));
  assign w_err_accept = w_operative && bus.valid_i && !w_hit && bus.grant_fifo_dest_i;
  assign w_dec        = resp_done_i && (r_count != '0);

  assign bus.valid_o     = w_issue ? w_dest : '0;
  assign bus.ready_o     = w_handshake || w_err_accept;
  assign bus.push_dest_o = w_handshake;
  assign bus.dest_o      = (bus.valid_i && !rst) ? w_dest : '0;
  assign sample_info_o   = w_err_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= OPERATIVE;
      r_count        <= '0;
      r_last_dest    <= '0;
      r_error_req    <= 1'b0;
      r_handle_error <= 1'b0;
    end else begin
      if (w_handshake && !w_dec && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_dec && !w_handshake) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (w_handshake) begin
        r_last_dest <= w_dest;
      end

      case (r_state)
        OPERATIVE: begin
          if (w_err_accept) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_count == '0) begin
            if (WRITE_MODE != 0) begin
              r_state        <= ACCEPT_WDATA;
              r_handle_error <= 1'b1;
            end else begin
              r_state     <= ERROR_RESP;
              r_error_req <= 1'b1;
            end
          end
        end
        ACCEPT_WDATA: begin
          if (wdata_error_completed_i) begin
            r_state        <= ERROR_RESP;
            r_handle_error <= 1'b0;
            r_error_req    <= 1'b1;
          end
        end
        ERROR_RESP: begin
          if (error_gnt_i) begin
            r_state     <= OPERATIVE;
            r_error_req <= 1'b0;
          end
        end
        default: begin
          r_state <= OPERATIVE;
        end
      endcase
    end
  end

  assign outstanding_o  = r_count;
  assign error_req_o    = r_error_req;
  assign handle_error_o = r_handle_error;

`ifdef AXI_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_err_accept && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign err_count_o = r_err_count;
`endif

  // A response retiring with nothing outstanding is dropped by the counter;
  // flag it since it points at an upstream bookkeeping bug.
  a_resp_underflow: assert property (@(posedge clk) disable iff (rst)
                                     !(resp_done_i && (r_count == '0)));

endmodule
